// File: rtl/stereo_volume_ramp_ctrl.sv
// Zipper-free volume/mute sequencer for the stereo upsampler-with-volume stage.
// Gain moves in STEP increments every TICKS_PER_STEP output samples; soft-mute
// ramps to zero before asserting mute, force_mute cuts to mute immediately.
module stereo_volume_ramp_ctrl #(
    parameter int unsigned STEP           = 1,
    parameter int unsigned TICKS_PER_STEP = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] target_volume,
    input  logic       mute_req,
    input  logic       force_mute,
    input  logic       sample_tick,
    output logic [7:0] volume,
    output logic       mute,
    output logic       busy,
    output logic       muted
);

    localparam int unsigned CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int unsigned VOL_W = 8;

    typedef enum logic [1:0] {
        ST_MUTED = 2'd0,
        ST_RAMP  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [VOL_W-1:0]   cur_vol;
    logic [VOL_W-1:0]   vol_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;

    logic [VOL_W-1:0]   goal_c;
    logic signed [VOL_W:0] diff_c;
    logic [VOL_W:0]     mag_c;
    logic [VOL_W-1:0]   step_vol_c;
    logic               last_tick_c;

    // Goal and the next ramp value: snap to goal when within one step, never overshoot.
    always_comb begin
        goal_c      = mute_req ? '0 : target_volume;
        diff_c      = $signed({1'b0, goal_c}) - $signed({1'b0, cur_vol});
        mag_c       = diff_c[VOL_W] ? (VOL_W+1)'(-diff_c) : (VOL_W+1)'(diff_c);
        last_tick_c = (cnt == CNT_W'(TICKS_PER_STEP - 1));
        if (mag_c <= (VOL_W+1)'(STEP)) begin
            step_vol_c = goal_c;
        end else if (diff_c[VOL_W]) begin
            step_vol_c = cur_vol - VOL_W'(STEP);
        end else begin
            step_vol_c = cur_vol + VOL_W'(STEP);
        end
    end

    // Next-state, next-volume and tick-counter logic.
    always_comb begin
        state_nx = state;
        vol_nx   = cur_vol;
        cnt_nx   = cnt;
        if (force_mute) begin
            state_nx = ST_MUTED;
            vol_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_MUTED: begin
                    vol_nx = '0;
                    cnt_nx = '0;
                    if (!mute_req) begin
                        state_nx = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (cur_vol == goal_c) begin
                        cnt_nx   = '0;
                        state_nx = (mute_req && (goal_c == '0)) ? ST_MUTED : ST_HOLD;
                    end else if (sample_tick) begin
                        if (last_tick_c) begin
                            cnt_nx = '0;
                            vol_nx = step_vol_c;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (goal_c != cur_vol) begin
                        state_nx = ST_RAMP;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = ST_MUTED;
                    vol_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State, volume and counter registers plus registered output decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_MUTED;
            cur_vol <= '0;
            cnt     <= '0;
            volume  <= '0;
            mute    <= 1'b1;
            busy    <= 1'b0;
            muted   <= 1'b1;
        end else begin
            state   <= state_nx;
            cur_vol <= vol_nx;
            cnt     <= cnt_nx;
            volume  <= vol_nx;
            mute    <= (state_nx == ST_MUTED);
            busy    <= (state_nx == ST_RAMP);
            muted   <= (state_nx == ST_MUTED);
        end
    end

endmodule

// File: tb/tb_stereo_volume_ramp_ctrl.sv
// Directed bench for stereo_volume_ramp_ctrl: STEP=1/TICKS_PER_STEP=4 main instance,
// STEP=7 instance for the coarse-step no-overshoot case; one tick every 8 clocks.
module tb_stereo_volume_ramp_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] target_volume;
    logic       mute_req;
    logic       force_mute;
    logic       sample_tick;

    logic [7:0] volume_a;
    logic       mute_a, busy_a, muted_a;
    logic [7:0] volume_b;
    logic       mute_b, busy_b, muted_b;

    int n_chk;
    int n_bad;

    stereo_volume_ramp_ctrl #(.STEP(1), .TICKS_PER_STEP(4)) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .target_volume (target_volume),
        .mute_req      (mute_req),
        .force_mute    (force_mute),
        .sample_tick   (sample_tick),
        .volume        (volume_a),
        .mute          (mute_a),
        .busy          (busy_a),
        .muted         (muted_a)
    );

    stereo_volume_ramp_ctrl #(.STEP(7), .TICKS_PER_STEP(4)) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .target_volume (target_volume),
        .mute_req      (mute_req),
        .force_mute    (force_mute),
        .sample_tick   (sample_tick),
        .volume        (volume_b),
        .mute          (mute_b),
        .busy          (busy_b),
        .muted         (muted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One output sample: seven idle clocks then a one-clock tick.
    task automatic tick_once();
        repeat (7) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk         = 0;
        n_bad         = 0;
        reset_n       = 1'b0;
        target_volume = 8'd8;
        mute_req      = 1'b0;
        force_mute    = 1'b0;
        sample_tick   = 1'b0;

        // 1: reset values, then ramp 0 -> 8
        repeat (2) @(negedge clk);
        chk("rst_volume", 32'(volume_a), 0);
        chk("rst_mute",   32'(mute_a),   1);
        chk("rst_busy",   32'(busy_a),   0);
        chk("rst_muted",  32'(muted_a),  1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t1_mute_off", 32'(mute_a),   0);
        chk("t1_busy_on",  32'(busy_a),   1);
        chk("t1_vol0",     32'(volume_a), 0);
        for (int k = 1; k <= 8; k++) begin
            ticks(3);
            chk("t1_hold_between", 32'(volume_a), 32'(k - 1));
            tick_once();
            chk("t1_step", 32'(volume_a), 32'(k));
        end
        chk("t1_busy_at_goal", 32'(busy_a), 1);
        @(negedge clk);
        chk("t1_busy_off", 32'(busy_a),  0);
        chk("t1_muted",    32'(muted_a), 0);

        // 2: ramp to 200, hold, then soft-mute down to 0
        target_volume = 8'd200;
        ticks(192 * 4);
        chk("t2_up_200", 32'(volume_a), 200);
        @(negedge clk);
        chk("t2_hold", 32'(busy_a), 0);
        mute_req = 1'b1;
        @(negedge clk);
        chk("t2_busy", 32'(busy_a), 1);
        chk("t2_mute_still_off", 32'(mute_a), 0);
        for (int k = 199; k >= 0; k--) begin
            ticks(4);
            chk("t2_down", 32'(volume_a), 32'(k));
        end
        chk("t2_mute_pending", 32'(mute_a), 0);
        @(negedge clk);
        chk("t2_mute",  32'(mute_a),  1);
        chk("t2_muted", 32'(muted_a), 1);
        chk("t2_busy_off", 32'(busy_a), 0);

        // 3: unmute toward 100, reverse to 20 at volume 40
        mute_req      = 1'b0;
        target_volume = 8'd100;
        @(negedge clk);
        chk("t3_unmute", 32'(mute_a), 0);
        ticks(40 * 4);
        chk("t3_at40", 32'(volume_a), 40);
        target_volume = 8'd20;
        for (int k = 39; k >= 20; k--) begin
            ticks(4);
            chk("t3_reverse", 32'(volume_a), 32'(k));
        end
        @(negedge clk);
        chk("t3_hold", 32'(busy_a), 0);
        ticks(8);
        chk("t3_stays20", 32'(volume_a), 20);

        // 4: STEP=7 instance, 0 -> 10 gives 7 then 10
        target_volume = 8'd10;
        do_reset();
        chk("t4_start", 32'(volume_b), 0);
        ticks(4);
        chk("t4_step7", 32'(volume_b), 7);
        ticks(4);
        chk("t4_step10", 32'(volume_b), 10);
        ticks(4);
        chk("t4_no_overshoot", 32'(volume_b), 10);
        chk("t4_hold", 32'(busy_b), 0);

        // 5: force_mute at volume 50 mid-ramp, then restart from 0
        target_volume = 8'd100;
        do_reset();
        ticks(50 * 4);
        chk("t5_at50", 32'(volume_a), 50);
        force_mute = 1'b1;
        @(negedge clk);
        chk("t5_vol0",  32'(volume_a), 0);
        chk("t5_mute",  32'(mute_a),   1);
        chk("t5_muted", 32'(muted_a),  1);
        chk("t5_busy",  32'(busy_a),   0);
        @(negedge clk);
        chk("t5_stay_muted", 32'(muted_a), 1);
        force_mute = 1'b0;
        @(negedge clk);
        chk("t5_rel_mute", 32'(mute_a), 0);
        chk("t5_rel_vol",  32'(volume_a), 0);
        ticks(4);
        chk("t5_restart", 32'(volume_a), 1);

        // 6: asynchronous reset mid-ramp, then frozen volume with no ticks in HOLD
        ticks(8);
        chk("t6_pre", 32'(volume_a), 3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_vol",   32'(volume_a), 0);
        chk("t6_async_mute",  32'(mute_a),   1);
        chk("t6_async_busy",  32'(busy_a),   0);
        chk("t6_async_muted", 32'(muted_a),  1);
        @(negedge clk);
        target_volume = 8'd5;
        reset_n       = 1'b1;
        ticks(5 * 4);
        @(negedge clk);
        chk("t6_hold5", 32'(volume_a), 5);
        chk("t6_busy",  32'(busy_a),   0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i % 100 == 99) chk("t6_frozen", 32'(volume_a), 5);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
